// File: rtl/dual_issue_sched.sv
// Issue-stage scheduler: pairs issue together, split over two cycles, or stall on load-use.
// Latency: combinational issue decision in the cycle the pair is presented; split pairs take two cycles.
// Backpressure: ex_ready=0 or a load-use stall holds the pair (d_ready=0); flush drops any pending slot1.
module dual_issue_sched #(
  parameter int ADDR_WIDTH = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ex_ready,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic                  d1_valid,
  input  logic [ADDR_WIDTH-1:0] d0_rd,
  input  logic                  d0_rdwen,
  input  logic                  d0_ld,
  input  logic [ADDR_WIDTH-1:0] d0_rs1,
  input  logic [ADDR_WIDTH-1:0] d0_rs2,
  input  logic                  d0_rs1_use,
  input  logic                  d0_rs2_use,
  input  logic [ADDR_WIDTH-1:0] d1_rd,
  input  logic [ADDR_WIDTH-1:0] d1_rs1,
  input  logic [ADDR_WIDTH-1:0] d1_rs2,
  input  logic                  d1_rdwen,
  input  logic                  d1_ld,
  input  logic                  d1_mem,
  input  logic                  d1_rs1_use,
  input  logic                  d1_rs2_use,
  output logic                  iss0_valid,
  output logic                  iss0_src,
  output logic                  iss1_valid,
  output logic                  sched_stall
);

  typedef enum logic {DUAL, SECOND} st_t;

  st_t                   st, st_nxt;
  logic                  run;
  logic [1:0]            ld_cnt;
  logic [1:0]            trk_vld;
  logic [ADDR_WIDTH-1:0] trk0_rd, trk1_rd;

  logic                  go;
  logic                  th0, th1, raw_ld;
  logic                  ld0, ld1;
  logic [ADDR_WIDTH-1:0] ld0_rd;

  // A source depends on a destination only if it is really read and is not x0.
  function automatic logic match(input logic [ADDR_WIDTH-1:0] rd,
                                 input logic [ADDR_WIDTH-1:0] rs,
                                 input logic                  en);
    return en & (rs == rd) & (rd != '0);
  endfunction

  // Either tracked load still in its shadow against a slot's used sources.
  function automatic logic trk_hit(input logic [ADDR_WIDTH-1:0] rs1,
                                   input logic                  u1,
                                   input logic [ADDR_WIDTH-1:0] rs2,
                                   input logic                  u2);
    logic h0, h1;
    h0 = trk_vld[0] & (match(trk0_rd, rs1, u1) | match(trk0_rd, rs2, u2));
    h1 = trk_vld[1] & (match(trk1_rd, rs1, u1) | match(trk1_rd, rs2, u2));
    return (ld_cnt != 2'd0) & (h0 | h1);
  endfunction

  assign go     = run & d_valid & ex_ready & ~flush;
  assign th0    = trk_hit(d0_rs1, d0_rs1_use, d0_rs2, d0_rs2_use);
  assign th1    = trk_hit(d1_rs1, d1_rs1_use, d1_rs2, d1_rs2_use);
  // Only load results are too late for the EX forwarding network.
  assign raw_ld = d0_ld & d0_rdwen &
                  (match(d0_rd, d1_rs1, d1_rs1_use) | match(d0_rd, d1_rs2, d1_rs2_use));

  // Issue decision and next state; everything defaults to idle/hold.
  always_comb begin
    st_nxt      = st;
    iss0_valid  = 1'b0;
    iss0_src    = 1'b0;
    iss1_valid  = 1'b0;
    d_ready     = 1'b0;
    sched_stall = 1'b0;
    if (go) begin
      case (st)
        DUAL: begin
          if (th0) begin
            sched_stall = 1'b1;
          end else if (d1_valid & (d1_mem | raw_ld | th1)) begin
            iss0_valid = 1'b1;
            st_nxt     = SECOND;
          end else begin
            iss0_valid = 1'b1;
            iss1_valid = d1_valid;
            d_ready    = 1'b1;
          end
        end
        SECOND: begin
          if (th1) begin
            sched_stall = 1'b1;
          end else begin
            iss0_valid = 1'b1;
            iss0_src   = 1'b1;
            d_ready    = 1'b1;
            st_nxt     = DUAL;
          end
        end
        default: st_nxt = DUAL;
      endcase
    end
    if (flush) st_nxt = DUAL;
  end

  // Loads actually leaving on each lane this cycle (writes to x0 never block anyone).
  assign ld0_rd = iss0_src ? d1_rd : d0_rd;
  assign ld0    = iss0_valid & (iss0_src ? (d1_ld & d1_rdwen) : (d0_ld & d0_rdwen)) &
                  (ld0_rd != '0);
  assign ld1    = iss1_valid & d1_ld & d1_rdwen & (d1_rd != '0);

  // State register; reset mid-split returns to DUAL and decode re-presents the pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= DUAL;
    else        st <= st_nxt;
  end

  // Run flop holds issue off for the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Load-use shadow: a new load restarts the window, otherwise it counts down and expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt  <= 2'd0;
      trk_vld <= 2'b00;
      trk0_rd <= '0;
      trk1_rd <= '0;
    end else if (flush) begin
      ld_cnt  <= 2'd0;
      trk_vld <= 2'b00;
      trk0_rd <= '0;
      trk1_rd <= '0;
    end else if (ld0 | ld1) begin
      ld_cnt <= 2'(LOAD_LAT);
      if (ld0 & ld1) begin
        trk0_rd <= ld0_rd;
        trk1_rd <= d1_rd;
        trk_vld <= 2'b11;
      end else begin
        trk0_rd <= ld0 ? ld0_rd : d1_rd;
        trk_vld <= 2'b01;
      end
    end else if (ld_cnt != 2'd0) begin
      ld_cnt <= ld_cnt - 2'd1;
      if (ld_cnt == 2'd1) trk_vld <= 2'b00;
    end
  end

endmodule

// File: tb/tb_dual_issue_sched.sv
// Directed bench for dual_issue_sched with LOAD_LAT=1.
// Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
// Expected vector order: {iss0_valid, iss0_src, iss1_valid, d_ready, sched_stall}.
module tb_dual_issue_sched;

  logic       clk = 1'b0;
  logic       rst_n, flush, ex_ready, d_valid, d_ready, d1_valid;
  logic [4:0] d0_rd, d0_rs1, d0_rs2, d1_rd, d1_rs1, d1_rs2;
  logic       d0_rdwen, d0_ld, d0_rs1_use, d0_rs2_use;
  logic       d1_rdwen, d1_ld, d1_mem, d1_rs1_use, d1_rs2_use;
  logic       iss0_valid, iss0_src, iss1_valid, sched_stall;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dual_issue_sched #(.ADDR_WIDTH(5), .LOAD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_ready(ex_ready),
    .d_valid(d_valid), .d_ready(d_ready), .d1_valid(d1_valid),
    .d0_rd(d0_rd), .d0_rdwen(d0_rdwen), .d0_ld(d0_ld),
    .d0_rs1(d0_rs1), .d0_rs2(d0_rs2), .d0_rs1_use(d0_rs1_use), .d0_rs2_use(d0_rs2_use),
    .d1_rd(d1_rd), .d1_rs1(d1_rs1), .d1_rs2(d1_rs2),
    .d1_rdwen(d1_rdwen), .d1_ld(d1_ld), .d1_mem(d1_mem),
    .d1_rs1_use(d1_rs1_use), .d1_rs2_use(d1_rs2_use),
    .iss0_valid(iss0_valid), .iss0_src(iss0_src), .iss1_valid(iss1_valid),
    .sched_stall(sched_stall)
  );

  // Present a decode pair; slot0 always writes rd and reads rs1 (rs2 when u2=1).
  task automatic pair(input logic dv, input logic d1v,
                      input logic [4:0] a_rd, input logic a_ld,
                      input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic a_u2,
                      input logic [4:0] b_rd, input logic b_wen, input logic b_ld,
                      input logic b_mem, input logic [4:0] b_rs1, input logic [4:0] b_rs2,
                      input logic b_u2);
    d_valid  = dv;    d1_valid = d1v;
    d0_rd    = a_rd;  d0_rdwen = 1'b1; d0_ld = a_ld;
    d0_rs1   = a_rs1; d0_rs2   = a_rs2; d0_rs1_use = 1'b1; d0_rs2_use = a_u2;
    d1_rd    = b_rd;  d1_rdwen = b_wen; d1_ld = b_ld; d1_mem = b_mem;
    d1_rs1   = b_rs1; d1_rs2   = b_rs2; d1_rs1_use = 1'b1; d1_rs2_use = b_u2;
  endtask

  // Sample outputs mid-cycle, compare, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    #2;
    obs = {iss0_valid, iss0_src, iss1_valid, d_ready, sched_stall};
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    // Independent pair: add x5,x1,x2 / sub x6,x7,x8
    pair(1, 1, 5, 0, 1, 2, 1, 6, 1, 0, 0, 7, 8, 1);
    @(negedge clk);
    cyc("reset", 5'b00000);
    rst_n = 1'b1;
    cyc("run_low", 5'b00000);
    cyc("dual_indep", 5'b10110);

    // lw x5,0(x1) / add x6,x5,x1: split then load-use stall on slot1
    pair(1, 1, 5, 1, 1, 0, 0, 6, 1, 0, 0, 5, 1, 1);
    cyc("ldu_split", 5'b10000);
    cyc("ldu_stall", 5'b00001);
    cyc("ldu_slot1", 5'b11010);

    // add x5 / sw x5,0(x2): memory op only on lane0
    pair(1, 1, 5, 0, 1, 2, 1, 0, 0, 0, 1, 2, 5, 1);
    cyc("mem_slot0", 5'b10000);
    cyc("mem_slot1", 5'b11010);

    // add x3 / lw x9 on lane1, then a pair whose slot0 reads x9
    pair(1, 1, 3, 0, 1, 2, 1, 9, 1, 1, 0, 4, 0, 0);
    cyc("x_ld_lane1", 5'b10110);
    pair(1, 1, 10, 0, 9, 1, 1, 11, 1, 0, 0, 2, 3, 1);
    cyc("x_stall", 5'b00001);
    cyc("x_release", 5'b10110);

    // lw x12 dual-issues; next pair's slot1 reads x12 so it splits, then slot1 is clear
    pair(1, 1, 12, 1, 1, 0, 0, 13, 1, 0, 0, 1, 2, 1);
    cyc("th1_ld", 5'b10110);
    pair(1, 1, 14, 0, 1, 2, 1, 15, 1, 0, 0, 12, 1, 1);
    cyc("th1_split", 5'b10000);
    cyc("th1_slot1", 5'b11010);

    // lw x0 / add x6,x0,x1 and then a single x0 consumer never block
    pair(1, 1, 0, 1, 1, 0, 0, 6, 1, 0, 0, 0, 1, 1);
    cyc("x0_pair", 5'b10110);
    pair(1, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("x0_single", 5'b10010);

    // Flush while in SECOND drops slot1; next pair issues dual
    pair(1, 1, 5, 0, 1, 2, 1, 0, 0, 0, 1, 2, 5, 1);
    cyc("fl_split", 5'b10000);
    flush = 1'b1;
    cyc("fl_cycle", 5'b00000);
    flush = 1'b0;
    pair(1, 1, 5, 0, 1, 2, 1, 6, 1, 0, 0, 7, 8, 1);
    cyc("fl_after", 5'b10110);

    // ex_ready low for three cycles mid-SECOND
    pair(1, 1, 5, 0, 1, 2, 1, 0, 0, 0, 1, 2, 5, 1);
    cyc("exr_split", 5'b10000);
    ex_ready = 1'b0;
    cyc("exr_hold0", 5'b00000);
    cyc("exr_hold1", 5'b00000);
    cyc("exr_hold2", 5'b00000);
    ex_ready = 1'b1;
    cyc("exr_slot1", 5'b11010);

    // ex_ready low during a load-use stall suppresses the stall; the window still expires
    pair(1, 1, 5, 1, 1, 0, 0, 6, 1, 0, 0, 5, 1, 1);
    cyc("exr_ld_split", 5'b10000);
    ex_ready = 1'b0;
    cyc("exr_nostall", 5'b00000);
    ex_ready = 1'b1;
    cyc("exr_ld_slot1", 5'b11010);

    // d1_valid without d_valid is ignored
    pair(0, 1, 5, 0, 1, 2, 1, 6, 1, 0, 0, 7, 8, 1);
    cyc("no_dvalid", 5'b00000);

    // Async reset in SECOND returns to DUAL; the pair is re-presented
    pair(1, 1, 5, 0, 1, 2, 1, 0, 0, 0, 1, 2, 5, 1);
    cyc("rst_split", 5'b10000);
    rst_n = 1'b0;
    cyc("rst_mid", 5'b00000);
    rst_n = 1'b1;
    cyc("rst_run_low", 5'b00000);
    cyc("rst_replay", 5'b10000);
    cyc("rst_slot1", 5'b11010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
